// File: rtl/punc_debug_scanner.sv
// Debug-port snapshot reader for PUnC. It walks PC, R0..R7 and then a memory
// window through the debug address ports, and streams each word over a valid/ready link.
module punc_debug_scanner #(
  parameter int DBG_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_base,
  input  logic [15:0] mem_len,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] mem_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_kind,
  output logic [15:0] out_addr,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] K_PC  = 2'd0;
  localparam logic [1:0] K_RF  = 2'd1;
  localparam logic [1:0] K_MEM = 2'd2;

  localparam logic [2:0] LAT_M1 = 3'((DBG_LAT > 0) ? (DBG_LAT - 1) : 0);

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [2:0]  rf_idx_q, rf_idx_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;
  logic [15:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [2:0]  wait_q, wait_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [2:0]  rf_addr_q, rf_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [1:0]  out_kind_q, out_kind_d;
  logic [15:0] out_addr_q, out_addr_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // An item closes the frame if it is R7 with an empty window, or the final window word.
  function automatic logic is_last_item(input logic [1:0]  kind,
                                        input logic [2:0]  rf_idx,
                                        input logic [15:0] cnt,
                                        input logic [15:0] len);
    logic res;
    res = 1'b0;
    if (kind == K_RF) begin
      res = (rf_idx == 3'd7) && (len == 16'd0);
    end else if (kind == K_MEM) begin
      res = (cnt == (len - 16'd1));
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  // Next-state, item sequencing and output register inputs.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    rf_idx_d    = rf_idx_q;
    mem_cnt_d   = mem_cnt_q;
    base_d      = base_q;
    len_d       = len_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    rf_addr_d   = rf_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_kind_d  = out_kind_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = mem_base;
          len_d     = mem_len;
          kind_d    = K_PC;
          rf_idx_d  = 3'd0;
          mem_cnt_d = 16'd0;
          busy_d    = 1'b1;
          state_d   = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR: begin
        if (kind_q == K_RF) begin
          rf_addr_d = rf_idx_q;
        end else if (kind_q == K_MEM) begin
          mem_addr_d = base_q + mem_cnt_q;
        end else begin
          rf_addr_d = rf_addr_q;
        end
        if (DBG_LAT > 0) begin
          wait_d  = LAT_M1;
          state_d = S_WAIT;
        end else begin
          state_d = S_CAPT;
        end
      end

      S_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = S_CAPT;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      S_CAPT: begin
        out_valid_d = 1'b1;
        out_kind_d  = kind_q;
        out_last_d  = is_last_item(kind_q, rf_idx_q, mem_cnt_q, len_q);
        case (kind_q)
          K_PC: begin
            out_data_d = pc_debug_data;
            out_addr_d = 16'd0;
          end
          K_RF: begin
            out_data_d = rf_debug_data;
            out_addr_d = {13'd0, rf_idx_q};
          end
          K_MEM: begin
            out_data_d = mem_debug_data;
            out_addr_d = mem_addr_q;
          end
          default: begin
            out_data_d = 16'd0;
            out_addr_d = 16'd0;
          end
        endcase
        state_d = S_SEND;
      end

      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // The last flag already ends the frame, so advancing never runs past the window.
            case (kind_q)
              K_PC: begin
                kind_d   = K_RF;
                rf_idx_d = 3'd0;
              end
              K_RF: begin
                if (rf_idx_q == 3'd7) begin
                  kind_d    = K_MEM;
                  mem_cnt_d = 16'd0;
                end else begin
                  rf_idx_d = rf_idx_q + 3'd1;
                end
              end
              K_MEM: begin
                mem_cnt_d = mem_cnt_q + 16'd1;
              end
              default: begin
                kind_d = K_PC;
              end
            endcase
            state_d = S_ADDR;
          end
        end else begin
          state_d = S_SEND;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_PC;
      rf_idx_q    <= 3'd0;
      mem_cnt_q   <= 16'd0;
      base_q      <= 16'd0;
      len_q       <= 16'd0;
      wait_q      <= 3'd0;
      mem_addr_q  <= 16'd0;
      rf_addr_q   <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
      out_kind_q  <= 2'd0;
      out_addr_q  <= 16'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      rf_idx_q    <= rf_idx_d;
      mem_cnt_q   <= mem_cnt_d;
      base_q      <= base_d;
      len_q       <= len_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      rf_addr_q   <= rf_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_kind_q  <= out_kind_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_debug_addr = mem_addr_q;
  assign rf_debug_addr  = rf_addr_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_kind       = out_kind_q;
  assign out_addr       = out_addr_q;
  assign out_last       = out_last_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
